instruction_loader: RTL and testbench
=====================================

# instruction_loader

Writer-side counterpart to the single-cycle CPU's instruction memory. It receives a program as a byte stream over a valid/ready handshake and writes it word by word into the instruction memory. While loading, it holds the CPU off. This lets new programs be loaded at run time, so they no longer need to be compiled into the memory image. It sits between the host byte source (UART receiver or testbench) and the instruction memory write port.

## Interface
- ADDR_WIDTH, 10, instruction memory address width (matches 10-bit fetch address)
- DEPTH, 56, number of instruction words the memory holds; largest legal program length

- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a load when idle, done or in error
- byte_in  in  8  stream byte
- byte_valid  in  1  byte_in is valid this cycle
- byte_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write enable, one cycle per word
- mem_addr  out  ADDR_WIDTH  word address being written
- mem_data  out  32  instruction word being written
- cpu_hold  out  1  high while a load is in progress; CPU must stall/stay in reset
- done  out  1  level; last load completed successfully
- error  out  1  level; last load aborted on a bad header
- words_loaded  out  ADDR_WIDTH  count of words written in the current/last load

## Operation
- Stream format: 2-byte word count N (big-endian), then 4*N bytes. Each instruction word is big-endian, MSB byte first. Word k goes to address k, starting at 0.
- Byte transfer occurs on a rising edge with byte_valid && byte_ready. byte_ready is a registered function of state only; it does not depend on byte_valid.
- States:
  - IDLE: byte_ready=0, cpu_hold=0. start goes to CNT_HI, clears done, error, words_loaded and mem_addr, and sets cpu_hold.
  - CNT_HI: byte_ready=1. On transfer, latch count[15:8] and go to CNT_LO.
  - CNT_LO: byte_ready=1. On transfer, latch count[7:0].
    - If the full count is 0 or exceeds DEPTH, go to ERROR.
    - Otherwise clear the byte index and go to DATA.
  - DATA: byte_ready=1. Each transfer shifts the byte into a 32-bit assembly register. After the 4th byte, go to WRITE.
  - WRITE: byte_ready=0. mem_we=1 for exactly this cycle, with mem_addr = current word index and mem_data = assembled word. On exit, words_loaded and mem_addr both increment.
    - If words_loaded+1 == N, go to DONE.
    - Otherwise go to DATA.
  - DONE: byte_ready=0, cpu_hold=0, done=1. start restarts the load (goes to CNT_HI).
  - ERROR: byte_ready=0, cpu_hold=0, error=1. No memory writes occur. start restarts the load.
- start is ignored in CNT_HI, CNT_LO, DATA and WRITE.
- Bytes presented while byte_ready=0 are not consumed; the source holds them.
- Memory is not cleared. Addresses at or beyond N keep their prior contents.

## Timing
- Reset: state=IDLE; byte_ready, mem_we, cpu_hold, done and error are 0; mem_addr, mem_data and words_loaded are 0; the assembly register is cleared.
- Reset asserted mid-load: the load aborts immediately to reset values. The partially written memory is left as-is. done is not set.
- cpu_hold rises on the edge after start is sampled in IDLE, DONE or ERROR. It falls on the edge entering DONE or ERROR.
- Per word: with byte_valid held high, the 4th byte transfers on edge t and mem_we is high during cycle t+1. The next byte transfers no earlier than edge t+2. Peak throughput is 5 cycles per word.
- Whole load with continuous valid: 2 + 5N cycles from the first header transfer to DONE.
- byte_valid gaps stall the FSM in its current state with no timeout.
- done and error are mutually exclusive and are never both high.
- mem_addr and mem_data are stable throughout the mem_we cycle. mem_we is never high outside WRITE.

## Test plan
- Reset then start, stream 00 02 / 30 02 00 07 / 7C 01 00 00 -> mem_we pulses twice: addr 0 data 0x30020007, then addr 1 data 0x7C010000. done=1, words_loaded=2, cpu_hold low after the second write, total 12 cycles.
- Header 00 00 -> error=1, no mem_we, byte_ready=0 after the header. Header 00 39 (57) -> error=1. Header 00 38 (56) with 224 bytes -> done=1, last write at addr 55.
- N=1 with byte_valid toggling every other cycle -> each byte consumed only on valid&&ready. Word 0x00000000 is written once at addr 0, and the byte order is preserved.
- start pulsed during DATA -> ignored; the load completes normally with the original N and mem_addr is not reset.
- Reset asserted after 2 of 4 data bytes -> all outputs go to reset values the next cycle. A fresh start with N=1 writes addr 0 using only the new bytes.
- After DONE, start with a new N=3 stream -> done clears at start, words_loaded restarts at 0, writes go to addrs 0..2, then done=1.

Source files
------------

// File: rtl/instruction_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_loader_if: byte-stream handshake and imem write port     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface instruction_loader_if #(
  parameter int ADDR_WIDTH = 10
) ();

  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_data;

  // Host side: drives the byte stream and observes the memory writes
  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_data
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_data
  );

endinterface
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_loader: loads a length-prefixed byte stream into imem    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instruction_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 56
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  instruction_loader_if.slave   bus,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_HI = 3'd1,
    S_CNT_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [15:0] c_DEPTH = 16'(DEPTH);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [15:0]           r_count;
  logic [1:0]            r_byte_idx;
  logic [31:0]           r_shift;
  logic [ADDR_WIDTH-1:0] r_words;

  logic                  w_accept;
  logic                  w_xfer;
  logic                  w_mem_we;
  logic                  w_cpu_hold;
  logic                  w_done;
  logic                  w_error;
  logic [15:0]           w_count_full;
  logic [ADDR_WIDTH-1:0] w_words_inc;
  logic                  w_last_word;
  logic                  w_bad_count;

  // Ready decodes the state register only, so it never combinationally depends on valid
  assign w_accept     = (r_state == S_CNT_HI) || (r_state == S_CNT_LO) || (r_state == S_DATA);
  assign w_xfer       = w_accept && bus.byte_valid;
  assign w_count_full = {r_count[15:8], bus.byte_in};
  assign w_bad_count  = (w_count_full == 16'd0) || (w_count_full > c_DEPTH);
  assign w_words_inc  = r_words + 1'b1;
  assign w_last_word  = (16'(w_words_inc) == r_count);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mem_we    = 1'b0;
    w_cpu_hold  = 1'b1;
    w_done      = 1'b0;
    w_error     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cpu_hold = 1'b0;
        if (start) w_state_nxt = S_CNT_HI;
      end
      S_CNT_HI: begin
        if (w_xfer) w_state_nxt = S_CNT_LO;
      end
      S_CNT_LO: begin
        if (w_xfer) w_state_nxt = w_bad_count ? S_ERROR : S_DATA;
      end
      S_DATA: begin
        if (w_xfer && (r_byte_idx == 2'd3)) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_mem_we    = 1'b1;
        w_state_nxt = w_last_word ? S_DONE : S_DATA;
      end
      S_DONE: begin
        w_cpu_hold = 1'b0;
        w_done     = 1'b1;
        if (start) w_state_nxt = S_CNT_HI;
      end
      S_ERROR: begin
        w_cpu_hold = 1'b0;
        w_error    = 1'b1;
        if (start) w_state_nxt = S_CNT_HI;
      end
      default: begin
        w_cpu_hold  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: header latch, word assembly and write index
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count    <= 16'd0;
      r_byte_idx <= 2'd0;
      r_shift    <= 32'd0;
      r_words    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) r_words <= '0;
        end
        S_CNT_HI: begin
          if (w_xfer) r_count[15:8] <= bus.byte_in;
        end
        S_CNT_LO: begin
          if (w_xfer) begin
            r_count[7:0] <= bus.byte_in;
            r_byte_idx   <= 2'd0;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_shift    <= {r_shift[23:0], bus.byte_in};
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          r_words <= w_words_inc;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.byte_ready = w_accept;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_addr   = r_words;
  assign bus.mem_data   = r_shift;
  assign cpu_hold       = w_cpu_hold;
  assign done           = w_done;
  assign error          = w_error;
  assign words_loaded   = r_words;

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instruction_loader: directed self-checking bench                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_instruction_loader;

  localparam int ADDR_WIDTH = 10;
  localparam int DEPTH      = 56;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  start;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;
  logic [ADDR_WIDTH-1:0] words_loaded;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_xfer  = 0;
  int n_both  = 0;
  int t0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  instruction_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  instruction_loader #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Observe writes and transfers mid-cycle, where all DUT outputs are settled
  always @(negedge clock) begin
    if (bus.mem_we) begin
      wr_addr.push_back(32'(bus.mem_addr));
      wr_data.push_back(bus.mem_data);
    end
    if (bus.byte_valid && bus.byte_ready) n_xfer++;
    if (done && error) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard          = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("byte_ready_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic send_gap(input logic [7:0] b);
    bus.byte_valid = 1'b0;
    tick();
    send_byte(b);
  endtask

  task automatic send_header(input logic [15:0] n);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic wait_end();
    int guard;
    guard          = 0;
    bus.byte_valid = 1'b0;
    while (!(done || error) && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) check("end_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_mem_we",     32'(bus.mem_we),     32'd0);
    check("rst_cpu_hold",   32'(cpu_hold),       32'd0);
    check("rst_done",       32'(done),           32'd0);
    check("rst_error",      32'(error),          32'd0);
    check("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    check("rst_mem_data",   bus.mem_data,        32'd0);
    check("rst_words",      32'(words_loaded),   32'd0);
    reset = 1'b0;
    tick();
    check("idle_ready", 32'(bus.byte_ready), 32'd0);

    // Two-word program, continuous valid
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check("t1_hold_rise", 32'(cpu_hold), 32'd1);
    check("t1_ready",     32'(bus.byte_ready), 32'd1);
    t0 = cyc;
    send_header(16'd2);
    check("t1_hold_mid", 32'(cpu_hold), 32'd1);
    send_word(32'h30020007);
    send_word(32'h7C010000);
    wait_end();
    check("t1_cycles",  32'(cyc - t0), 32'd12);
    check("t1_nwrites", 32'(wr_addr.size()), 32'd2);
    check("t1_addr0",   wr_addr[0], 32'd0);
    check("t1_data0",   wr_data[0], 32'h30020007);
    check("t1_addr1",   wr_addr[1], 32'd1);
    check("t1_data1",   wr_data[1], 32'h7C010000);
    check("t1_done",    32'(done), 32'd1);
    check("t1_error",   32'(error), 32'd0);
    check("t1_words",   32'(words_loaded), 32'd2);
    check("t1_hold",    32'(cpu_hold), 32'd0);
    check("t1_ready",   32'(bus.byte_ready), 32'd0);

    // Zero-length header
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check("t2_done_clr", 32'(done), 32'd0);
    send_header(16'd0);
    bus.byte_valid = 1'b0;
    check("t2_error", 32'(error), 32'd1);
    check("t2_ready", 32'(bus.byte_ready), 32'd0);
    check("t2_hold",  32'(cpu_hold), 32'd0);
    check("t2_done",  32'(done), 32'd0);
    tick();
    check("t2_error_hold", 32'(error), 32'd1);
    check("t2_nwrites", 32'(wr_addr.size()), 32'd0);

    // One over capacity
    pulse_start();
    check("t3_error_clr", 32'(error), 32'd0);
    check("t3_hold",      32'(cpu_hold), 32'd1);
    send_header(16'd57);
    bus.byte_valid = 1'b0;
    check("t3_error", 32'(error), 32'd1);
    tick();
    check("t3_nwrites", 32'(wr_addr.size()), 32'd0);

    // Full-capacity program
    pulse_start();
    send_header(16'd56);
    for (int k = 0; k < 56; k++)
      send_word({8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)});
    wait_end();
    check("t4_done",     32'(done), 32'd1);
    check("t4_error",    32'(error), 32'd0);
    check("t4_words",    32'(words_loaded), 32'd56);
    check("t4_nwrites",  32'(wr_addr.size()), 32'd56);
    check("t4_lastaddr", wr_addr[55], 32'd55);
    check("t4_lastdata", wr_data[55], 32'hDCDDDEDF);

    // N=1 with gaps between every byte
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    n_xfer = 0;
    send_gap(8'h00); send_gap(8'h01);
    for (int i = 0; i < 4; i++) send_gap(8'h00);
    wait_end();
    check("t5_xfers",   32'(n_xfer), 32'd6);
    check("t5_nwrites", 32'(wr_addr.size()), 32'd1);
    check("t5_addr",    wr_addr[0], 32'd0);
    check("t5_data",    wr_data[0], 32'h00000000);
    check("t5_done",    32'(done), 32'd1);
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_gap(8'h00); send_gap(8'h01);
    send_gap(8'h12); send_gap(8'h34); send_gap(8'h56); send_gap(8'h78);
    wait_end();
    check("t5b_nwrites", 32'(wr_addr.size()), 32'd1);
    check("t5b_data",    wr_data[0], 32'h12345678);

    // start during DATA is ignored
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_header(16'd2);
    send_word(32'h11223344);
    send_byte(8'h55);
    bus.byte_valid = 1'b0;
    pulse_start();
    check("t6_words", 32'(words_loaded), 32'd1);
    check("t6_addr",  32'(bus.mem_addr), 32'd1);
    check("t6_hold",  32'(cpu_hold), 32'd1);
    check("t6_done",  32'(done), 32'd0);
    check("t6_ready", 32'(bus.byte_ready), 32'd1);
    send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    wait_end();
    check("t6_nwrites", 32'(wr_addr.size()), 32'd2);
    check("t6_addr1",   wr_addr[1], 32'd1);
    check("t6_data1",   wr_data[1], 32'h55667788);
    check("t6_fwords",  32'(words_loaded), 32'd2);
    check("t6_fdone",   32'(done), 32'd1);

    // Reset mid-word, then a fresh single-word load
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_header(16'd1);
    send_byte(8'hAA); send_byte(8'hBB);
    bus.byte_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("t7_ready",    32'(bus.byte_ready), 32'd0);
    check("t7_hold",     32'(cpu_hold), 32'd0);
    check("t7_done",     32'(done), 32'd0);
    check("t7_error",    32'(error), 32'd0);
    check("t7_words",    32'(words_loaded), 32'd0);
    check("t7_mem_data", bus.mem_data, 32'd0);
    reset = 1'b0;
    tick();
    check("t7_nwrites0", 32'(wr_addr.size()), 32'd0);
    pulse_start();
    send_header(16'd1);
    send_word(32'hDEADBEEF);
    wait_end();
    check("t7_nwrites", 32'(wr_addr.size()), 32'd1);
    check("t7_addr",    wr_addr[0], 32'd0);
    check("t7_data",    wr_data[0], 32'hDEADBEEF);

    // Reload after DONE
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check("t8_done_clr", 32'(done), 32'd0);
    check("t8_words0",   32'(words_loaded), 32'd0);
    check("t8_hold",     32'(cpu_hold), 32'd1);
    send_header(16'd3);
    send_word(32'hA0000001);
    send_word(32'hB0000002);
    send_word(32'hC0000003);
    wait_end();
    check("t8_nwrites", 32'(wr_addr.size()), 32'd3);
    check("t8_addr0", wr_addr[0], 32'd0);
    check("t8_addr2", wr_addr[2], 32'd2);
    check("t8_data1", wr_data[1], 32'hB0000002);
    check("t8_data2", wr_data[2], 32'hC0000003);
    check("t8_done",  32'(done), 32'd1);
    check("t8_words", 32'(words_loaded), 32'd3);

    check("done_error_excl", 32'(n_both), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
